light_dance_checker: RTL and testbench
======================================

Name: light_dance_checker

Overview:
Receive-side counterpart of the LightDance serial signature generator. It consumes a serial frame of DATA_BITS payload bits followed by 8 check bits and recomputes the same 8-bit feedback-shift signature over the payload. At frame end it compares the computed signature with the received check bits and reports pass or fail. It sits on the receive path of the smart-house light-pattern link.

Parameters:
DATA_BITS, 32, payload bits per frame; legal range 1..65535.
SEED, 8'h00, signature register value at frame start; must match the generator's pdata load value.

Ports:
clk  input  1  clock, rising edge
arst  input  1  asynchronous reset, active-high
sof  input  1  start of frame; qualified by bit_valid; marks the first payload bit
bit_valid  input  1  bit_in is valid this cycle
bit_in  input  1  serial bit, payload first, then check bits
busy  output  1  frame in progress (DATA or CHECK state)
done  output  1  one-cycle pulse when a frame's last check bit is consumed
crc_ok  output  1  last completed frame matched; held until the next done
crc_err  output  1  last completed frame mismatched; held until the next done
remainder  output  8  signature computed over the last payload; held until the next done

Behaviour:
- Reset (arst=1, asynchronous): state=IDLE; internal signature reg=SEED; bit counter=0; busy=0, done=0, crc_ok=0, crc_err=0, remainder=8'h00.
- Signature update per accepted payload bit d, register q[7:0]:
  n7=q0^d, n6=q7, n5=q0^q6, n4=q0^q5, n3=q4, n2=q3, n1=q0^q2, n0=q0^q1.
- Generator convention: check bits are the final register contents, sent q[0] first through q[7].
- A bit is accepted only in a cycle where bit_valid=1. bit_valid=0 stalls with no state change.
- IDLE:
  - bit_valid&sof: q<=update(SEED, bit_in), cnt<=1, go to DATA.
  - If DATA_BITS==1, go directly to CHECK instead.
  - bit_valid without sof is ignored.
- DATA: each accepted bit updates q and increments cnt. The bit making cnt==DATA_BITS moves to CHECK, with the check index k=0 and the mismatch flag cleared.
- CHECK: each accepted bit is compared to q[k] and ORed into the mismatch flag; k increments. On k==7 accepted:
  - done=1 for exactly one cycle.
  - remainder<=q.
  - crc_ok<=~mismatch_final; crc_err<=mismatch_final.
  - Return to IDLE.
  - The signature register is reloaded with SEED when the next frame starts.
- Output latency: done, crc_ok, crc_err and remainder all update on the clock edge that accepts the 8th check bit; they are visible the following cycle.
- sof&bit_valid in DATA or CHECK aborts the current frame:
  - No done pulse; crc_ok, crc_err and remainder are unchanged.
  - The bit is taken as payload bit 1 of a new frame (same as from IDLE).
- busy=1 in DATA and CHECK; 0 in IDLE. busy deasserts in the same cycle done asserts.
- Back-to-back frames: sof may arrive in the cycle immediately after the last check bit, with no idle gap required.
- arst mid-frame: immediate return to reset values; the partial frame is discarded.
- Counter widths: cnt is 16 bits; k is 3 bits.

Optional Feature:
Macro LIGHT_DANCE_ERRCNT_EN.
- Defined: adds output err_count[7:0], reset to 0. It increments on each done with crc_err=1 and saturates at 8'hFF. A one-cycle clr_err_count input clears it; if the clear coincides with an increment, the clear wins.
- Undefined: neither port nor the counter logic exists.

Test Plan:
1. DATA_BITS=8, SEED=0: payload 1,0,0,0,0,0,0,0 then check 1,0,0,0,0,0,0,0 -> done pulse, crc_ok=1, crc_err=0, remainder=8'h01.
2. Same frame with check bit index 3 flipped (1,0,0,1,0,0,0,0) -> done, crc_err=1, crc_ok=0, remainder=8'h01.
3. DATA_BITS=8, all-zero payload and all-zero check bits -> crc_ok=1, remainder=8'h00; then the case-1 frame back-to-back with no gap -> second done, crc_ok=1, remainder=8'h01.
4. Case-1 frame with random bit_valid=0 gaps (about 50%) -> identical result to case 1; busy held high throughout the frame.
5. Abort and reset: sof mid-DATA after 4 bits, then a full case-1 frame -> exactly one done, crc_ok=1. Separately, assert arst during CHECK -> all outputs 0 at once, no done.
6. Random payloads for DATA_BITS=32 against a bench model of the generator equations, including corrupted frames -> crc_ok/crc_err match the model for 1000 frames. With LIGHT_DANCE_ERRCNT_EN defined, err_count equals the number of corrupted frames, saturating at 255.

Source files
------------

// File: rtl/light_dance_checker.sv
// light_dance_checker: receive-side checker for the LightDance serial
// signature. Recomputes the 8-bit feedback-shift signature over DATA_BITS
// payload bits. It then compares that signature with the 8 check bits that
// follow, which arrive q[0] first.
// Optional build macro: LIGHT_DANCE_ERRCNT_EN adds a saturating error counter
// (err_count) with a one-cycle clear input (clr_err_count).
//
// Input handshake: a bit is consumed only in a cycle with bit_valid=1.
// bit_valid=0 is a stall with no state change. sof is meaningful only
// together with bit_valid. It always starts a new frame, which aborts any
// frame already in progress without a done pulse.
module light_dance_checker #(
  parameter int          DATA_BITS = 32,
  parameter logic [7:0]  SEED      = 8'h00
) (
  input  logic       clk,
  input  logic       arst,
  input  logic       sof,
  input  logic       bit_valid,
  input  logic       bit_in,
`ifdef LIGHT_DANCE_ERRCNT_EN
  input  logic       clr_err_count,
  output logic [7:0] err_count,
`endif
  output logic       busy,
  output logic       done,
  output logic       crc_ok,
  output logic       crc_err,
  output logic [7:0] remainder
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DATA  = 2'd1,
    ST_CHECK = 2'd2
  } state_t;

  localparam logic [15:0] LAST_CNT      = 16'(DATA_BITS);
  // A one-bit payload is complete as soon as its first bit is taken.
  localparam logic        START_TO_CHECK = (LAST_CNT == 16'd1);

  state_t      state_q, state_d;
  logic [7:0]  sig_q, sig_d;
  logic [15:0] cnt_q, cnt_d;
  logic [2:0]  k_q, k_d;
  logic        mis_q, mis_d;
  logic        done_q, done_d;
  logic        ok_q, ok_d;
  logic        err_q, err_d;
  logic [7:0]  rem_q, rem_d;

  logic        start;
  logic        data_acc;
  logic        chk_acc;
  logic        data_last;
  logic        chk_last;
  logic        mis_final;
  logic [15:0] cnt_inc;

  // One signature step for payload bit d.
  function automatic logic [7:0] sig_step(input logic [7:0] q, input logic d);
    logic [7:0] n;
    n[7] = q[0] ^ d;
    n[6] = q[7];
    n[5] = q[0] ^ q[6];
    n[4] = q[0] ^ q[5];
    n[3] = q[4];
    n[2] = q[3];
    n[1] = q[0] ^ q[2];
    n[0] = q[0] ^ q[1];
    return n;
  endfunction

  // Decode which kind of bit is being accepted this cycle.
  always_comb begin
    start     = bit_valid & sof;
    data_acc  = bit_valid & ~sof & (state_q == ST_DATA);
    chk_acc   = bit_valid & ~sof & (state_q == ST_CHECK);
    cnt_inc   = cnt_q + 16'd1;
    data_last = data_acc & (cnt_inc == LAST_CNT);
    chk_last  = chk_acc & (k_q == 3'd7);
    mis_final = mis_q | (bit_in ^ sig_q[k_q]);
  end

  // State register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  // Next-state logic; sof always restarts, overriding the current phase.
  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = START_TO_CHECK ? ST_CHECK : ST_DATA;
    end else begin
      case (state_q)
        ST_DATA:  if (data_last) state_d = ST_CHECK;
        ST_CHECK: if (chk_last)  state_d = ST_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  // FSM outputs.
  always_comb begin
    busy = (state_q != ST_IDLE);
  end

  // Signature, counters and result next values.
  always_comb begin
    sig_d  = sig_q;
    cnt_d  = cnt_q;
    k_d    = k_q;
    mis_d  = mis_q;
    done_d = 1'b0;
    ok_d   = ok_q;
    err_d  = err_q;
    rem_d  = rem_q;
    if (start) begin
      sig_d = sig_step(SEED, bit_in);
      cnt_d = 16'd1;
      k_d   = 3'd0;
      mis_d = 1'b0;
    end else if (data_acc) begin
      sig_d = sig_step(sig_q, bit_in);
      cnt_d = cnt_inc;
      if (data_last) begin
        k_d   = 3'd0;
        mis_d = 1'b0;
      end
    end else if (chk_acc) begin
      mis_d = mis_final;
      k_d   = k_q + 3'd1;
      if (chk_last) begin
        done_d = 1'b1;
        rem_d  = sig_q;
        ok_d   = ~mis_final;
        err_d  = mis_final;
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      sig_q  <= SEED;
      cnt_q  <= 16'd0;
      k_q    <= 3'd0;
      mis_q  <= 1'b0;
      done_q <= 1'b0;
      ok_q   <= 1'b0;
      err_q  <= 1'b0;
      rem_q  <= 8'h00;
    end else begin
      sig_q  <= sig_d;
      cnt_q  <= cnt_d;
      k_q    <= k_d;
      mis_q  <= mis_d;
      done_q <= done_d;
      ok_q   <= ok_d;
      err_q  <= err_d;
      rem_q  <= rem_d;
    end
  end

  assign done      = done_q;
  assign crc_ok    = ok_q;
  assign crc_err   = err_q;
  assign remainder = rem_q;

`ifdef LIGHT_DANCE_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of failed frames; clear beats a same-cycle increment.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (clr_err_count) begin
      err_cnt_d = 8'h00;
    end else if (chk_last && mis_final && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'h01;
    end
  end

  // Error counter register.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) err_cnt_q <= 8'h00;
    else      err_cnt_q <= err_cnt_d;
  end

  assign err_count = err_cnt_q;
`endif

endmodule

// File: tb/tb_light_dance_checker.sv
// Directed bench for light_dance_checker: an 8-bit-payload instance (SEED 0)
// and a 32-bit-payload instance (SEED 8'hA5) share clock, reset and inputs.
module tb_light_dance_checker;

  logic       clk = 1'b0;
  logic       arst = 1'b1;
  logic       sof = 1'b0;
  logic       bit_valid = 1'b0;
  logic       bit_in = 1'b0;

  logic       busy8, done8, ok8, err8;
  logic [7:0] rem8;
  logic       busy32, done32, ok32, err32;
  logic [7:0] rem32;

`ifdef LIGHT_DANCE_ERRCNT_EN
  logic       clr = 1'b0;
  logic [7:0] errcnt8, errcnt32;
  logic [7:0] exp_errcnt = 8'h00;
  logic       clr_on_last = 1'b0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  light_dance_checker #(.DATA_BITS(8), .SEED(8'h00)) dut8 (
    .clk(clk), .arst(arst), .sof(sof), .bit_valid(bit_valid), .bit_in(bit_in),
`ifdef LIGHT_DANCE_ERRCNT_EN
    .clr_err_count(clr), .err_count(errcnt8),
`endif
    .busy(busy8), .done(done8), .crc_ok(ok8), .crc_err(err8), .remainder(rem8)
  );

  light_dance_checker #(.DATA_BITS(32), .SEED(8'hA5)) dut32 (
    .clk(clk), .arst(arst), .sof(sof), .bit_valid(bit_valid), .bit_in(bit_in),
`ifdef LIGHT_DANCE_ERRCNT_EN
    .clr_err_count(clr), .err_count(errcnt32),
`endif
    .busy(busy32), .done(done32), .crc_ok(ok32), .crc_err(err32), .remainder(rem32)
  );

  // Generator model written from the signature equations.
  function automatic logic [7:0] gen_step(input logic [7:0] q, input logic d);
    logic [7:0] n;
    n = {q[0] ^ d, q[7], q[0] ^ q[6], q[0] ^ q[5], q[4], q[3], q[0] ^ q[2], q[0] ^ q[1]};
    return n;
  endfunction

  task automatic check1(input string tag, input logic obs, input logic exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0b expected %0b", tag, obs, exp);
    end
  endtask

  task automatic check8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; return just after the rising edge.
  task automatic drive(input logic s, input logic v, input logic b);
    @(negedge clk);
    sof = s;
    bit_valid = v;
    bit_in = b;
    @(posedge clk);
    #1;
  endtask

  // One full frame into dut8; payload bit 0 and check bit 0 go first.
  task automatic frame8(input logic [7:0] pay, input logic [7:0] chk, input int gap_pct);
    logic [15:0] bits;
    bits = {chk, pay};
    for (int i = 0; i < 16; i++) begin
      while ($urandom_range(0, 99) < gap_pct) begin
        drive(1'b0, 1'b0, 1'($urandom_range(0, 1)));
        check1("gap_busy8", busy8, i > 0);
        check1("gap_done8", done8, 1'b0);
      end
      drive(i == 0, 1'b1, bits[i]);
      if (i < 15) begin
        check1("mid_busy8", busy8, 1'b1);
        check1("mid_done8", done8, 1'b0);
      end
    end
  endtask

  task automatic expect8(input string tag, input logic ok, input logic [7:0] rem);
    check1({tag, "_done"}, done8, 1'b1);
    check1({tag, "_busy"}, busy8, 1'b0);
    check1({tag, "_ok"}, ok8, ok);
    check1({tag, "_err"}, err8, ~ok);
    check8({tag, "_rem"}, rem8, rem);
  endtask

  // One frame into dut32 against the generator model, optionally corrupted.
  task automatic frame32(input logic [31:0] pay, input logic corrupt, input int flip);
    logic [7:0] q;
    logic [7:0] chk;
    q = 8'hA5;
    for (int i = 0; i < 32; i++) q = gen_step(q, pay[i]);
    chk = q;
    if (corrupt) chk[flip] = ~chk[flip];
    for (int i = 0; i < 32; i++) begin
      drive(i == 0, 1'b1, pay[i]);
      if (i == 0) check1("f32_done_low", done32, 1'b0);
    end
    for (int j = 0; j < 8; j++) begin
`ifdef LIGHT_DANCE_ERRCNT_EN
      if (j == 7 && clr_on_last) clr = 1'b1;
`endif
      drive(1'b0, 1'b1, chk[j]);
`ifdef LIGHT_DANCE_ERRCNT_EN
      clr = 1'b0;
`endif
    end
    check1("f32_done", done32, 1'b1);
    check1("f32_ok", ok32, ~corrupt);
    check1("f32_err", err32, corrupt);
    check8("f32_rem", rem32, q);
`ifdef LIGHT_DANCE_ERRCNT_EN
    if (clr_on_last) exp_errcnt = 8'h00;
    else if (corrupt && exp_errcnt != 8'hFF) exp_errcnt = exp_errcnt + 8'h01;
    check8("f32_errcnt", errcnt32, exp_errcnt);
`endif
  endtask

  initial begin
    logic [15:0] c1_bits;
    c1_bits = {8'h01, 8'h01};

    // Reset state.
    #2;
    check1("rst_busy8", busy8, 1'b0);
    check1("rst_done8", done8, 1'b0);
    check1("rst_ok8", ok8, 1'b0);
    check1("rst_err8", err8, 1'b0);
    check8("rst_rem8", rem8, 8'h00);
`ifdef LIGHT_DANCE_ERRCNT_EN
    check8("rst_errcnt8", errcnt8, 8'h00);
`endif
    @(negedge clk);
    @(negedge clk);
    arst = 1'b0;

    // Valid bits without sof in IDLE are ignored.
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b1);
      check1("idle_ignore_busy", busy8, 1'b0);
    end

    // Case 1: good frame.
    frame8(8'h01, 8'h01, 0);
    expect8("c1", 1'b1, 8'h01);
    drive(1'b0, 1'b0, 1'b0);
    check1("c1_done_pulse", done8, 1'b0);
    check1("c1_ok_held", ok8, 1'b1);

    // Case 2: check bit 3 flipped.
    frame8(8'h01, 8'h09, 0);
    expect8("c2", 1'b0, 8'h01);
    drive(1'b0, 1'b0, 1'b0);
    check1("c2_err_held", err8, 1'b1);

    // Case 3: all-zero frame, then case-1 frame with no gap.
    frame8(8'h00, 8'h00, 0);
    expect8("c3a", 1'b1, 8'h00);
    frame8(8'h01, 8'h01, 0);
    expect8("c3b", 1'b1, 8'h01);

    // Case 4: failing frame, then case-1 frame with ~50% stalls.
    frame8(8'h01, 8'h09, 0);
    expect8("c4pre", 1'b0, 8'h01);
    frame8(8'h01, 8'h01, 50);
    expect8("c4", 1'b1, 8'h01);

    // Case 5a: abort after 4 payload bits; prior failing result stays held.
    frame8(8'h01, 8'h09, 0);
    expect8("c5pre", 1'b0, 8'h01);
    drive(1'b1, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b1);
    drive(1'b0, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 1'b1);
    check1("abort_busy", busy8, 1'b1);
    check1("abort_done", done8, 1'b0);
    frame8(8'h01, 8'h01, 0);
    check1("abort_held_err", err8, 1'b0);
    expect8("c5", 1'b1, 8'h01);
    drive(1'b0, 1'b0, 1'b0);
    check1("c5_single_done", done8, 1'b0);

    // Case 5b: reset during CHECK clears everything immediately.
    for (int i = 0; i < 11; i++) drive(i == 0, 1'b1, c1_bits[i]);
    check1("pre_arst_busy", busy8, 1'b1);
    #2;
    arst = 1'b1;
    #1;
    check1("arst_busy8", busy8, 1'b0);
    check1("arst_done8", done8, 1'b0);
    check1("arst_ok8", ok8, 1'b0);
    check1("arst_err8", err8, 1'b0);
    check8("arst_rem8", rem8, 8'h00);
    check1("arst_busy32", busy32, 1'b0);
    check8("arst_rem32", rem32, 8'h00);
    @(negedge clk);
    arst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b0, 1'b1, c1_bits[11 + (i % 5)]);
      check1("post_arst_done", done8, 1'b0);
      check1("post_arst_busy", busy8, 1'b0);
    end

    // Case 6: random 32-bit payloads against the model, ~half corrupted.
    for (int f = 0; f < 1000; f++) begin
      frame32($urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 7));
    end

`ifdef LIGHT_DANCE_ERRCNT_EN
    // Clear coinciding with an increment wins, then counting resumes.
    clr_on_last = 1'b1;
    frame32($urandom, 1'b1, 2);
    clr_on_last = 1'b0;
    frame32($urandom, 1'b1, 5);
    @(negedge clk);
    clr = 1'b1;
    sof = 1'b0;
    bit_valid = 1'b0;
    @(posedge clk);
    #1;
    clr = 1'b0;
    check8("errcnt_clear", errcnt32, 8'h00);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
